// File: rtl/hps_io_responder.sv
// hps_io_responder
// Core-side end of the 16-bit host IO link. Decodes UIO commands (joystick,
// status, buttons) and FPGA file-transfer commands, and streams download data
// to the core over the ioctl port, holding the host off with IO_WAIT while a
// word is waiting to be written.
module hps_io_responder #(
  parameter int unsigned ADDR_W         = 25,
  parameter logic [31:0] STATUS_DEFAULT = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              IO_UIO,
  input  logic              IO_FPGA,
  input  logic              IO_STROBE,
  input  logic [15:0]       IO_DOUT,
  output logic [15:0]       IO_DIN,
  output logic              IO_WAIT,
  input  logic [31:0]       joystick_0,
  output logic [31:0]       status,
  output logic              status_update,
  output logic [15:0]       buttons,
  output logic              ioctl_download,
  output logic [7:0]        ioctl_index,
  output logic              ioctl_wr,
  output logic [ADDR_W-1:0] ioctl_addr,
  output logic [15:0]       ioctl_dout,
  input  logic              ioctl_wait
);

  localparam logic [15:0] CMD_JOY_READ    = 16'h0001;
  localparam logic [15:0] CMD_STATUS_SET  = 16'h001E;
  localparam logic [15:0] CMD_STATUS_GET  = 16'h0029;
  localparam logic [15:0] CMD_BUTTONS_SET = 16'h0030;
  localparam logic [15:0] CMD_FILE_TX     = 16'h0053;
  localparam logic [15:0] CMD_FILE_TX_DAT = 16'h0054;
  localparam logic [15:0] CMD_FILE_INDEX  = 16'h0055;

  localparam logic [ADDR_W-1:0] ADDR_STEP = {{(ADDR_W-2){1'b0}}, 2'b10};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_WR   = 2'd2
  } wr_state_t;

  // Word counter advances but sticks at 15 so long payloads never alias word 1.
  function automatic logic [3:0] wcnt_inc(input logic [3:0] cnt);
    if (cnt == 4'd15) begin
      return 4'd15;
    end else begin
      return cnt + 4'd1;
    end
  endfunction

  // Registers
  logic              frame_r;
  logic [15:0]       cmd_r;
  logic [3:0]        wcnt_r;
  logic [15:0]       io_din_r;
  logic              io_wait_r;
  logic [31:0]       status_r;
  logic              status_update_r;
  logic [15:0]       buttons_r;
  logic              download_r;
  logic [7:0]        index_r;
  logic [ADDR_W-1:0] addr_r;
  logic [15:0]       dout_r;
  wr_state_t         state_r;

  // Combinational decode
  wr_state_t         state_next_s;
  logic              frame_s;
  logic              uio_s;
  logic              fpga_s;
  logic              frame_fall_s;
  logic              stb_ok_s;
  logic              cmd_stb_s;
  logic              pay_stb_s;
  logic              uio_pay_s;
  logic              fpga_pay_s;
  logic              st_lo_s;
  logic              st_hi_s;
  logic              btn_s;
  logic              file_tx_s;
  logic              file_index_s;
  logic              tx_dat_s;
  logic              download_next_s;
  logic [15:0]       rd_data_s;

  // UIO takes priority when both frame lines are up; FPGA decoding is then muted.
  assign frame_s      = IO_UIO | IO_FPGA;
  assign uio_s        = IO_UIO;
  assign fpga_s       = IO_FPGA & ~IO_UIO;
  assign frame_fall_s = frame_r & ~frame_s;

  // A strobe while IO_WAIT is high is a host protocol error and is dropped whole.
  assign stb_ok_s     = IO_STROBE & ~io_wait_r & frame_s;
  assign cmd_stb_s    = stb_ok_s & (wcnt_r == 4'd0);
  assign pay_stb_s    = stb_ok_s & (wcnt_r != 4'd0);
  assign uio_pay_s    = pay_stb_s & uio_s;
  assign fpga_pay_s   = pay_stb_s & fpga_s;

  assign st_lo_s      = uio_pay_s & (cmd_r == CMD_STATUS_SET) & (wcnt_r == 4'd1);
  assign st_hi_s      = uio_pay_s & (cmd_r == CMD_STATUS_SET) & (wcnt_r == 4'd2);
  assign btn_s        = uio_pay_s & (cmd_r == CMD_BUTTONS_SET) & (wcnt_r == 4'd1);
  assign file_tx_s    = fpga_pay_s & (cmd_r == CMD_FILE_TX) & (wcnt_r == 4'd1);
  assign file_index_s = fpga_pay_s & (cmd_r == CMD_FILE_INDEX) & (wcnt_r == 4'd1);
  assign tx_dat_s     = fpga_pay_s & (cmd_r == CMD_FILE_TX_DAT) & download_r;

  // Readback word for the current payload slot; unknown commands read as zero.
  always_comb begin
    rd_data_s = 16'h0000;
    if (uio_s) begin
      case (cmd_r)
        CMD_JOY_READ: begin
          if (wcnt_r == 4'd1) begin
            rd_data_s = joystick_0[15:0];
          end else if (wcnt_r == 4'd2) begin
            rd_data_s = joystick_0[31:16];
          end else begin
            rd_data_s = 16'h0000;
          end
        end
        CMD_STATUS_GET: begin
          if (wcnt_r == 4'd1) begin
            rd_data_s = status_r[15:0];
          end else if (wcnt_r == 4'd2) begin
            rd_data_s = status_r[31:16];
          end else begin
            rd_data_s = 16'h0000;
          end
        end
        default: rd_data_s = 16'h0000;
      endcase
    end else begin
      rd_data_s = 16'h0000;
    end
  end

  // Download flag as it will be after this edge, so IO_WAIT reacts without lag.
  always_comb begin
    download_next_s = download_r;
    if (file_tx_s) begin
      download_next_s = (IO_DOUT != 16'h0000);
    end else begin
      download_next_s = download_r;
    end
  end

  // Write FSM next state: a data word goes straight to WR unless the core stalls.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (tx_dat_s) begin
          state_next_s = ioctl_wait ? ST_PEND : ST_WR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (!ioctl_wait) begin
          state_next_s = ST_WR;
        end else begin
          state_next_s = ST_PEND;
        end
      end
      ST_WR:   state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Write FSM state register; reset lands in IDLE so ioctl_wr drops at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Frame tracking: command latch, word counter, clear on frame end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_r <= 1'b0;
      cmd_r   <= 16'h0000;
      wcnt_r  <= 4'd0;
    end else begin
      frame_r <= frame_s;
      if (frame_fall_s) begin
        cmd_r  <= 16'h0000;
        wcnt_r <= 4'd0;
      end else if (cmd_stb_s) begin
        cmd_r  <= IO_DOUT;
        wcnt_r <= 4'd1;
      end else if (pay_stb_s) begin
        wcnt_r <= wcnt_inc(wcnt_r);
      end
    end
  end

  // Host-facing registers: readback word and the IO_WAIT hold-off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_din_r  <= 16'h0000;
      io_wait_r <= 1'b0;
    end else begin
      io_wait_r <= (state_next_s != ST_IDLE) | (download_next_s & ioctl_wait);
      if (cmd_stb_s) begin
        io_din_r <= 16'h0000;
      end else if (pay_stb_s) begin
        io_din_r <= rd_data_s;
      end
    end
  end

  // UIO-written registers; status_update only fires once the high half lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_r        <= STATUS_DEFAULT;
      status_update_r <= 1'b0;
      buttons_r       <= 16'h0000;
    end else begin
      status_update_r <= st_hi_s;
      if (st_lo_s) begin
        status_r[15:0] <= IO_DOUT;
      end
      if (st_hi_s) begin
        status_r[31:16] <= IO_DOUT;
      end
      if (btn_s) begin
        buttons_r <= IO_DOUT;
      end
    end
  end

  // File-transfer registers: download flag, index, data word and byte address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      download_r <= 1'b0;
      index_r    <= 8'h00;
      dout_r     <= 16'h0000;
      addr_r     <= ADDR_ZERO;
    end else begin
      download_r <= download_next_s;
      if (file_index_s) begin
        index_r <= IO_DOUT[7:0];
      end
      if (tx_dat_s) begin
        dout_r <= IO_DOUT;
      end
      if (state_r == ST_WR) begin
        addr_r <= addr_r + ADDR_STEP;
      end else if (file_tx_s && (IO_DOUT != 16'h0000)) begin
        addr_r <= ADDR_ZERO;
      end
    end
  end

  assign IO_DIN         = io_din_r;
  assign IO_WAIT        = io_wait_r;
  assign status         = status_r;
  assign status_update  = status_update_r;
  assign buttons        = buttons_r;
  assign ioctl_download = download_r;
  assign ioctl_index    = index_r;
  assign ioctl_wr       = (state_r == ST_WR);
  assign ioctl_addr     = addr_r;
  assign ioctl_dout     = dout_r;

endmodule

// File: tb/tb_hps_io_responder.sv
// Directed bench for hps_io_responder: readback and ioctl writes are checked
// against expectations queued when the stimulus is driven.
module tb_hps_io_responder;

  logic        clk;
  logic        reset_n;
  logic        IO_UIO;
  logic        IO_FPGA;
  logic        IO_STROBE;
  logic [15:0] IO_DOUT;
  logic [15:0] IO_DIN;
  logic        IO_WAIT;
  logic [31:0] joystick_0;
  logic [31:0] status;
  logic        status_update;
  logic [15:0] buttons;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        ioctl_wait;

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         wr_q[$];
  logic [15:0] din_q[$];
  wr_t         mon_e;
  int          compared   = 0;
  int          mismatched = 0;
  int          wr_seen    = 0;
  int          upd_cnt    = 0;

  hps_io_responder dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .IO_UIO         (IO_UIO),
    .IO_FPGA        (IO_FPGA),
    .IO_STROBE      (IO_STROBE),
    .IO_DOUT        (IO_DOUT),
    .IO_DIN         (IO_DIN),
    .IO_WAIT        (IO_WAIT),
    .joystick_0     (joystick_0),
    .status         (status),
    .status_update  (status_update),
    .buttons        (buttons),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: every ioctl_wr must match the next queued write.
  always @(negedge clk) begin
    if (ioctl_wr === 1'b1) begin
      wr_seen++;
      if (wr_q.size() == 0) begin
        check("wr_unexpected", {127'd0, ioctl_wr}, 128'd0);
      end else begin
        mon_e = wr_q.pop_front();
        check("wr_addr", {103'd0, ioctl_addr}, {103'd0, mon_e.addr});
        check("wr_data", {112'd0, ioctl_dout}, {112'd0, mon_e.data});
      end
    end
    if (status_update === 1'b1) upd_cnt++;
  end

  task automatic wait_ready();
    int n = 0;
    while (IO_WAIT !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("io_wait_timeout", {127'd0, IO_WAIT}, 128'd0);
  endtask

  task automatic strobe(input logic [15:0] w, input logic stall);
    @(negedge clk);
    wait_ready();
    IO_DOUT    = w;
    IO_STROBE  = 1'b1;
    ioctl_wait = stall;
    @(negedge clk);
    IO_STROBE  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] w, input logic [15:0] exp);
    logic [15:0] e;
    din_q.push_back(exp);
    strobe(w, 1'b0);
    e = din_q.pop_front();
    check(tag, {112'd0, IO_DIN}, {112'd0, e});
  endtask

  task automatic frame_on(input logic u, input logic f);
    @(negedge clk);
    IO_UIO  = u;
    IO_FPGA = f;
  endtask

  task automatic frame_off();
    @(negedge clk);
    IO_UIO  = 1'b0;
    IO_FPGA = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    IO_UIO     = 1'b0;
    IO_FPGA    = 1'b0;
    IO_STROBE  = 1'b0;
    IO_DOUT    = 16'h0000;
    ioctl_wait = 1'b0;
    joystick_0 = 32'hA5A5_1234;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          {IO_DIN, IO_WAIT, status, status_update, buttons, ioctl_download,
           ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout}, 128'd0);
    reset_n = 1'b1;

    // JOY_READ
    frame_on(1'b1, 1'b0);
    strobe(16'h0001, 1'b0);
    rd("joy_lo", 16'h0000, 16'h1234);
    rd("joy_hi", 16'h0000, 16'hA5A5);
    repeat (3) @(negedge clk);
    check("din_hold", {112'd0, IO_DIN}, {112'd0, 16'hA5A5});
    rd("joy_extra", 16'h0000, 16'h0000);
    frame_off();

    // STATUS_SET then STATUS_GET
    frame_on(1'b1, 1'b0);
    strobe(16'h001E, 1'b0);
    strobe(16'hBEEF, 1'b0);
    check("upd_early", {127'd0, status_update}, 128'd0);
    strobe(16'hDEAD, 1'b0);
    check("upd_pulse", {127'd0, status_update}, 128'd1);
    check("status_set", {96'd0, status}, {96'd0, 32'hDEAD_BEEF});
    @(negedge clk);
    check("upd_one_clk", {127'd0, status_update}, 128'd0);
    frame_off();
    frame_on(1'b1, 1'b0);
    strobe(16'h0029, 1'b0);
    rd("status_get_lo", 16'h0000, 16'hBEEF);
    rd("status_get_hi", 16'h0000, 16'hDEAD);
    frame_off();

    // BUTTONS_SET and an unknown command
    frame_on(1'b1, 1'b0);
    strobe(16'h0030, 1'b0);
    strobe(16'h5A5A, 1'b0);
    frame_off();
    check("buttons", {112'd0, buttons}, {112'd0, 16'h5A5A});
    frame_on(1'b1, 1'b0);
    strobe(16'h0077, 1'b0);
    rd("unknown_cmd", 16'h1357, 16'h0000);
    frame_off();

    // Partial STATUS_SET: low half kept, no update, next frame fresh
    frame_on(1'b1, 1'b0);
    strobe(16'h001E, 1'b0);
    strobe(16'h00FF, 1'b0);
    frame_off();
    repeat (2) @(negedge clk);
    check("partial_status", {96'd0, status}, {96'd0, 32'hDEAD_00FF});
    check("partial_no_upd", 128'(upd_cnt), 128'd1);
    frame_on(1'b1, 1'b0);
    strobe(16'h0029, 1'b0);
    rd("fresh_get_lo", 16'h0000, 16'h00FF);
    rd("fresh_get_hi", 16'h0000, 16'hDEAD);
    frame_off();

    // Download: index 3, two words, end
    frame_on(1'b0, 1'b1);
    strobe(16'h0055, 1'b0);
    strobe(16'h0003, 1'b0);
    frame_off();
    check("ioctl_index", {120'd0, ioctl_index}, {120'd0, 8'h03});
    frame_on(1'b0, 1'b1);
    strobe(16'h0053, 1'b0);
    strobe(16'h0001, 1'b0);
    frame_off();
    check("download_on", {127'd0, ioctl_download}, 128'd1);
    frame_on(1'b0, 1'b1);
    strobe(16'h0054, 1'b0);
    wr_q.push_back('{addr: 25'd0, data: 16'h1111});
    strobe(16'h1111, 1'b0);
    wr_q.push_back('{addr: 25'd2, data: 16'h2222});
    strobe(16'h2222, 1'b0);
    frame_off();
    frame_on(1'b0, 1'b1);
    strobe(16'h0053, 1'b0);
    strobe(16'h0000, 1'b0);
    frame_off();
    check("download_off", {127'd0, ioctl_download}, 128'd0);
    check("addr_after", {103'd0, ioctl_addr}, {103'd0, 25'd4});

    // Core stall for ten clocks, with a dropped protocol-error strobe inside
    frame_on(1'b0, 1'b1);
    strobe(16'h0053, 1'b0);
    strobe(16'h0001, 1'b0);
    frame_off();
    frame_on(1'b0, 1'b1);
    strobe(16'h0054, 1'b0);
    wr_q.push_back('{addr: 25'd0, data: 16'h3333});
    strobe(16'h3333, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("stall_io_wait", {127'd0, IO_WAIT}, 128'd1);
      check("stall_no_wr", {127'd0, ioctl_wr}, 128'd0);
      check("stall_dout", {112'd0, ioctl_dout}, {112'd0, 16'h3333});
      if (i == 4) begin
        IO_DOUT   = 16'h9999;
        IO_STROBE = 1'b1;
      end else begin
        IO_STROBE = 1'b0;
      end
      @(negedge clk);
    end
    IO_STROBE  = 1'b0;
    ioctl_wait = 1'b0;
    @(negedge clk);
    check("stall_release_wr", {127'd0, ioctl_wr}, 128'd1);
    check("wait_during_wr", {127'd0, IO_WAIT}, 128'd1);
    @(negedge clk);
    check("wait_after_wr", {127'd0, IO_WAIT}, 128'd0);
    frame_off();
    frame_on(1'b0, 1'b1);
    strobe(16'h0053, 1'b0);
    strobe(16'h0000, 1'b0);
    frame_off();
    check("stall_addr", {103'd0, ioctl_addr}, {103'd0, 25'd2});

    // UIO and FPGA together: data strobes must not write
    frame_on(1'b0, 1'b1);
    strobe(16'h0053, 1'b0);
    strobe(16'h0001, 1'b0);
    frame_off();
    frame_on(1'b1, 1'b1);
    strobe(16'h0054, 1'b0);
    strobe(16'hAAAA, 1'b0);
    strobe(16'hBBBB, 1'b0);
    frame_off();
    repeat (3) @(negedge clk);
    check("both_no_wr", 128'(wr_seen), 128'd3);

    // Reset while a write is pending
    frame_on(1'b0, 1'b1);
    strobe(16'h0054, 1'b0);
    strobe(16'hCCCC, 1'b1);
    check("pend_before_rst", {127'd0, IO_WAIT}, 128'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset",
          {IO_DIN, IO_WAIT, status, status_update, buttons, ioctl_download,
           ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout}, 128'd0);
    @(negedge clk);
    IO_FPGA    = 1'b0;
    ioctl_wait = 1'b0;
    reset_n    = 1'b1;
    repeat (5) @(negedge clk);
    check("no_wr_after_rst", 128'(wr_seen), 128'd3);
    check("wr_q_drained", 128'(wr_q.size()), 128'd0);
    check("upd_total", 128'(upd_cnt), 128'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
